// File: rtl/ysyx_25030077_pkg.sv
// Shared definitions for the load unit: funct3 encodings, FSM states and
// the request legality/alignment decode used at accept time.
package ysyx_25030077_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } load_state_e;

  // True when the load must be answered with an error instead of a memory
  // access: unknown funct3, a 64-bit-only load on a 32-bit datapath, or an
  // address that is not naturally aligned for the access size.
  function automatic logic load_bad(input logic [2:0] funct3,
                                    input logic [2:0] offset,
                                    input logic       wide);
    logic bad;
    case (funct3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = offset[0];
      F3_LW:         bad = |offset[1:0];
      F3_LWU:        bad = !wide || (|offset[1:0]);
      F3_LD:         bad = !wide || (|offset);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_25030077_load_extend.sv
// Lane select and sign/zero extension of an aligned memory word.
module ysyx_25030077_load_extend
  import ysyx_25030077_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                 funct3,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  logic [XLEN-1:0]            word,
  output logic [XLEN-1:0]            data
);

  logic [XLEN-1:0] lane;

  // Shift the addressed byte to bit 0, then extend according to the load type.
  always_comb begin
    lane = word >> {offset, 3'b000};
    data = '0;
    case (funct3)
      F3_LB:   data = XLEN'($signed(lane[7:0]));
      F3_LH:   data = XLEN'($signed(lane[15:0]));
      F3_LW:   data = XLEN'($signed(lane[31:0]));
      F3_LBU:  data = XLEN'(lane[7:0]);
      F3_LHU:  data = XLEN'(lane[15:0]);
      F3_LWU:  data = XLEN'(lane[31:0]);
      F3_LD:   data = lane;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_25030077_mem_load.sv
// RISC-V load unit: computes the effective address, issues one aligned word
// read, waits for the response with a timeout, and returns the extended data.
module ysyx_25030077_mem_load
  import ysyx_25030077_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data
);

  localparam int         OFFW     = $clog2(XLEN/8);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  load_state_e     state, state_next;
  logic [XLEN-1:0] ea;
  logic [OFFW-1:0] ea_offset;
  logic [OFFW-1:0] offset_q;
  logic [2:0]      funct3_q;
  logic [15:0]     wait_cnt;
  logic            req_bad;
  logic            timed_out;
  logic [XLEN-1:0] ext_data;

  assign ea        = in_rs1 + in_imm;
  assign ea_offset = ea[OFFW-1:0];
  assign req_bad   = load_bad(in_funct3, 3'(ea_offset), XLEN == 64);
  assign timed_out = (wait_cnt == CNT_LAST);

  assign in_ready      = (state == ST_IDLE);
  assign mem_req_valid = (state == ST_REQ);
  assign out_valid     = (state == ST_RESP);

  ysyx_25030077_load_extend #(.XLEN(XLEN)) u_extend (
    .funct3 (funct3_q),
    .offset (offset_q),
    .word   (mem_resp_data),
    .data   (ext_data)
  );

  // State register; reset abandons whatever transaction is in flight.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state decode; a response in the last wait cycle beats the timeout.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid) state_next = req_bad ? ST_RESP : ST_REQ;
      ST_REQ:  if (mem_req_ready) state_next = ST_WAIT;
      ST_WAIT: if (mem_resp_valid || timed_out) state_next = ST_RESP;
      ST_RESP: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request capture, wait counter and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      funct3_q <= '0;
      offset_q <= '0;
      mem_addr <= '0;
      wait_cnt <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            funct3_q <= in_funct3;
            offset_q <= ea_offset;
            mem_addr <= {ea[XLEN-1:OFFW], {OFFW{1'b0}}};
            wait_cnt <= '0;
            out_data <= '0;
            out_err  <= req_bad;
          end
        end
        ST_REQ: begin
          if (mem_req_ready) wait_cnt <= '0;
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            out_data <= ext_data;
            out_err  <= 1'b0;
          end else if (timed_out) begin
            out_data <= '0;
            out_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030077_mem_load.sv
// Randomised scoreboard bench for the load unit (XLEN=32, TIMEOUT=4).
module tb_ysyx_25030077_mem_load;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_imm;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic            out_err;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_addr;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;

  int total = 0;
  int bad   = 0;
  bit stall_out = 1'b0;
  logic [32:0] sb[$];

  ysyx_25030077_mem_load #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_funct3      (in_funct3),
    .in_rs1         (in_rs1),
    .in_imm         (in_imm),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_err        (out_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Hard stop in case something wedges beyond every local bound.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Expected {err, data} from the load rules: legality, natural alignment,
  // timeout, then byte-lane pick and sign/zero extension by arithmetic.
  function automatic logic [32:0] ref_load(input logic [31:0] ea,
                                           input logic [2:0] f3,
                                           input logic [31:0] word,
                                           input int delay);
    logic [63:0] v;
    logic [63:0] span;
    int nbytes;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return {1'b1, 32'h0};
    nbytes = 1 << f3[1:0];
    if ((ea % 32'(nbytes)) != 32'd0) return {1'b1, 32'h0};
    if (delay >= TIMEOUT) return {1'b1, 32'h0};
    span = 64'd1 << (8 * nbytes);
    v = ({32'h0, word} >> (8 * (ea % 32'd4))) % span;
    if (f3[2] == 1'b0 && nbytes < 4 && v >= span / 64'd2)
      v = v + 64'h1_0000_0000 - span;
    return {1'b0, v[31:0]};
  endfunction

  // One load: present request, play memory (stall cycles on mem_req_ready,
  // response in WAIT cycle 'delay'), optionally reset mid-WAIT.
  task automatic applyStimulus(input logic [31:0] rs1, input logic [31:0] imm,
                               input logic [2:0] f3, input logic [31:0] word,
                               input int stall, input int delay,
                               input bit hold_out, input bit do_reset_in);
    logic [31:0] ea;
    logic [32:0] exp;
    logic [32:0] probe;
    bit access;
    bit do_reset;
    int kend;
    int klast;
    int budget;
    int dly;
    ea = rs1 + imm;
    probe = ref_load(ea, f3, word, 0);
    access = !probe[32];
    do_reset = do_reset_in && access;
    dly = do_reset ? 3 : delay;
    exp = ref_load(ea, f3, word, dly);

    budget = 0;
    while (!in_ready && budget < 200) begin
      @(negedge clock);
      budget++;
    end
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    if (!in_ready) return;

    if (hold_out && !do_reset) stall_out = 1'b1;
    if (!do_reset) sb.push_back(exp);
    in_valid  = 1'b1;
    in_funct3 = f3;
    in_rs1    = rs1;
    in_imm    = imm;
    @(posedge clock);
    @(negedge clock);
    in_valid  = 1'b0;
    in_funct3 = 3'($urandom);
    in_rs1    = $urandom;
    in_imm    = $urandom;

    if (!access) begin
      checkOutput("err_latency_valid", 32'(out_valid), 32'd1);
      checkOutput("err_no_mem_req", 32'(mem_req_valid), 32'd0);
    end else begin
      checkOutput("mem_req_valid", 32'(mem_req_valid), 32'd1);
      checkOutput("mem_addr", mem_addr, {ea[31:2], 2'b00});
      repeat (stall) begin
        mem_req_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checkOutput("mem_addr_hold", mem_addr, {ea[31:2], 2'b00});
        checkOutput("mem_req_hold", 32'(mem_req_valid), 32'd1);
      end
      mem_req_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      mem_req_ready = 1'b0;
      kend  = (dly < TIMEOUT) ? dly : TIMEOUT - 1;
      klast = (dly > kend) ? dly : kend;
      for (int k = 0; k <= klast; k++) begin
        if (do_reset && k == 1) reset = 1'b1;
        mem_resp_valid = (k == dly);
        mem_resp_data  = (k == dly) ? word : $urandom;
        @(posedge clock);
        @(negedge clock);
        mem_resp_valid = 1'b0;
        mem_resp_data  = $urandom;
        if (do_reset && k == 1) begin
          reset = 1'b0;
          checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
          checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
          checkOutput("rst_mem_req", 32'(mem_req_valid), 32'd0);
          checkOutput("rst_mem_addr", mem_addr, 32'd0);
          checkOutput("rst_out_data", out_data, 32'd0);
          checkOutput("rst_out_err", 32'(out_err), 32'd0);
        end else if (!do_reset && k == kend) begin
          checkOutput("resp_latency", 32'(out_valid), 32'd1);
        end else if (!do_reset && k < kend) begin
          checkOutput("wait_no_valid", 32'(out_valid), 32'd0);
        end
      end
    end

    if (hold_out && !do_reset) begin
      repeat (10) @(negedge clock);
      stall_out = 1'b0;
    end
  endtask

  // Monitor: pops the scoreboard on each new result, then checks that the
  // result stays frozen and in_ready stays low until it is taken.
  initial begin
    logic [32:0] e;
    logic [31:0] held_data;
    logic        held_err;
    bit pending;
    pending   = 1'b0;
    held_data = '0;
    held_err  = 1'b0;
    out_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pending = 1'b0;
      end else if (out_valid) begin
        if (!pending) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_result", 32'(out_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("out_err", 32'(out_err), 32'(e[32]));
            checkOutput("out_data", out_data, e[31:0]);
          end
          held_data = out_data;
          held_err  = out_err;
          pending   = 1'b1;
        end else begin
          checkOutput("out_data_stable", out_data, held_data);
          checkOutput("out_err_stable", 32'(out_err), 32'(held_err));
        end
        checkOutput("in_ready_in_resp", 32'(in_ready), 32'd0);
      end else begin
        pending = 1'b0;
      end
      out_ready = stall_out ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Main sequence: reset, directed corner cases, then random loads.
  initial begin
    logic [31:0] rs1;
    logic [31:0] imm;
    int budget;
    reset          = 1'b1;
    in_valid       = 1'b0;
    in_funct3      = '0;
    in_rs1         = '0;
    in_imm         = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", out_data, 32'd0);
    checkOutput("reset_out_err", 32'(out_err), 32'd0);
    checkOutput("reset_mem_req", 32'(mem_req_valid), 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);

    // Byte loads from 0x1122_8344 at offsets 3 and 1, signed and unsigned.
    applyStimulus(32'h8000_0000, 32'h3, 3'b000, 32'h1122_8344, 0, 0, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'h1, 3'b100, 32'h1122_8344, 0, 0, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'h1, 3'b000, 32'h1122_8344, 0, 0, 1'b0, 1'b0);
    // Misaligned halfword, then illegal LD on a 32-bit datapath.
    applyStimulus(32'h8000_0001, 32'h0, 3'b001, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0);
    applyStimulus(32'h0000_1000, 32'h0, 3'b011, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0);
    // Word load with a stalled request and a late-ish response.
    applyStimulus(32'h0000_2000, 32'h4, 3'b010, 32'hCAFE_F00D, 3, 2, 1'b0, 1'b0);
    // Response in the last allowed cycle, then a timeout with a late pulse.
    applyStimulus(32'h0000_3000, 32'h2, 3'b101, 32'h8765_4321, 0, TIMEOUT - 1, 1'b0, 1'b0);
    applyStimulus(32'h0000_3000, 32'h0, 3'b010, 32'h1234_5678, 1, TIMEOUT + 2, 1'b0, 1'b0);
    applyStimulus(32'h0000_3000, 32'h0, 3'b010, 32'h1234_5678, 0, 1, 1'b0, 1'b0);
    // Consumer holds off for ten cycles.
    applyStimulus(32'h0000_4000, 32'h2, 3'b001, 32'hF00F_0FF0, 0, 0, 1'b1, 1'b0);
    // Reset in WAIT, late response afterwards, then a normal load.
    applyStimulus(32'h0000_5000, 32'h0, 3'b010, 32'hAAAA_5555, 0, 3, 1'b0, 1'b1);
    applyStimulus(32'h0000_5000, 32'h0, 3'b010, 32'h0BAD_CAFE, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      rs1 = $urandom;
      imm = $urandom;
      if ($urandom_range(0, 1) == 1) imm = ($urandom & 32'hFFFF_FFFC) - rs1 + 32'($urandom_range(0, 3) * (($urandom_range(0, 2) == 0) ? 1 : 0));
      applyStimulus(rs1, imm, 3'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 6),
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 24) == 0));
    end

    budget = 0;
    while (sb.size() != 0 && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_25030077_mem_load.md
YSYX_25030077_MEM_LOAD -- requirements
Module: ysyx_25030077_MEM_load

Interface
REQ-001 Parameter XLEN, default 32, datapath/address width; legal values 32 and 64.
REQ-002 Parameter TIMEOUT, default 255, max cycles waiting for mem_resp_valid before error; range 1..65535.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  load request valid.
REQ-006 in_ready  output  1  unit accepts request this cycle.
REQ-007 in_funct3  input  3  RISC-V load funct3 (LB/LH/LW/LBU/LHU; LD/LWU only if XLEN=64).
REQ-008 in_rs1  input  XLEN  base register value.
REQ-009 in_imm  input  XLEN  sign-extended offset.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_data  output  XLEN  extended load data; zero when out_err=1.
REQ-013 out_err  output  1  misaligned, illegal funct3, or timeout.
REQ-014 mem_req_valid  output  1  memory read request.
REQ-015 mem_req_ready  input  1  memory accepts request.
REQ-016 mem_addr  output  XLEN  word-aligned address (low log2(XLEN/8) bits zero).
REQ-017 mem_resp_valid  input  1  read data returned; single-cycle pulse, no backpressure.
REQ-018 mem_resp_data  input  XLEN  full aligned word.

Function
REQ-019 States IDLE, REQ, WAIT, RESP; in_ready=1 only in IDLE.
REQ-020 Accept (in_valid & in_ready): latch ea = in_rs1 + in_imm modulo 2^XLEN, funct3, byte offset ea[log2(XLEN/8)-1:0].
REQ-021 Accept with legal, aligned request -> REQ; illegal funct3 or misalignment (H odd, W not 4-aligned, D not 8-aligned) -> RESP with out_err=1, no memory access.
REQ-022 REQ: mem_req_valid=1, mem_addr stable until mem_req_ready; on mem_req_ready -> WAIT, clear timeout counter.
REQ-023 WAIT: on mem_resp_valid capture extracted data -> RESP; counter increments each cycle without response; reaching TIMEOUT -> RESP with out_err=1.
REQ-024 mem_resp_valid in same cycle counter reaches TIMEOUT: data wins, out_err=0.
REQ-025 mem_resp_valid outside WAIT ignored.
REQ-026 Extraction: select lane by byte offset; B/H/W sign-extend bit 7/15/31; BU/HU/WU zero-extend; D passes word.
REQ-027 RESP: out_valid=1, out_data/out_err held stable until out_ready; out_valid & out_ready -> IDLE.
REQ-028 Minimum latency accept-to-out_valid: 2 cycles with mem_req_ready=1 at REQ entry and mem_resp_valid the following cycle; error path: 1 cycle.
REQ-029 No new request accepted in same cycle as result handoff (in_ready returns next cycle).

Reset
REQ-030 reset asserted at any state -> IDLE next edge, abandoning in-flight transaction; late mem_resp_valid afterwards ignored.
REQ-031 Reset values: in_ready=1, out_valid=0, out_data=0, out_err=0, mem_req_valid=0, mem_addr=0, counter=0.

Structure
REQ-032 Shared package ysyx_25030077_pkg holds funct3 load encodings and state enum.
REQ-033 One sub-module ysyx_25030077_load_extend: combinational lane select and sign/zero extension, parameterised by XLEN.

Verification
REQ-034 XLEN=32, rs1=0x8000_0000, imm=0x3, LB, memory 0x1122_8344 -> mem_addr=0x8000_0000, out_data=0x0000_0011 (byte 0x11 positive); LBU of byte 0x83 at offset 1 -> 0x0000_0083; LB -> 0xFFFF_FF83.
REQ-035 LH at ea=0x8000_0001 -> no mem_req_valid, out_err=1, out_data=0, out_valid one cycle after accept.
REQ-036 LW, mem_req_ready low 3 cycles, response after 5 cycles -> mem_addr held 4 cycles, out_data = word, out_err=0.
REQ-037 TIMEOUT=4, no response -> out_err=1 exactly 4 cycles after WAIT entry; later mem_resp_valid ignored, next load correct.
REQ-038 out_ready low 10 cycles in RESP -> out_data/out_err stable, in_ready=0 throughout.
REQ-039 XLEN=64, LWU ea=0x...04, data 0xF000_0000_0000_0000 -> out_data=0x0000_0000_F000_0000; reset asserted in WAIT -> IDLE, in_ready=1 next cycle.
